ahb_addr_decoder: RTL

AHB_ADDR_DECODER -- requirements
Module: ahb_addr_decoder

---
 rtl/ahb_addr_decoder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ahb_addr_decoder.sv
// AHB address decoder, data-phase response mux and default (error) slave with unmapped-access statistics.
// Latency: HSEL_S is combinational; the data-phase mux adds no latency; statistics update on the edge that starts an error.
// Backpressure: sel_q and the default slave advance only when HREADY=1; a stalling slave freezes the data-phase select.
module ahb_addr_decoder #(
    parameter int                          NUM_SLAVES = 2,
    parameter int                          DATA_W     = 32,
    parameter logic [16*NUM_SLAVES-1:0]    SLV_BASE   = {16'hC000, 16'hC080},
    parameter logic [16*NUM_SLAVES-1:0]    SLV_MASK   = {16'hFFFF, 16'hFFFF}
) (
    input  logic                           HCLK,
    input  logic                           HRESET,
    input  logic [31:0]                    HADDR,
    input  logic [1:0]                     HTRANS,
    input  logic [NUM_SLAVES-1:0]          HREADY_S,
    input  logic [NUM_SLAVES-1:0]          HRESP_S,
    input  logic [NUM_SLAVES*DATA_W-1:0]   HRDATA_S,
    input  logic                           ERR_CLR,
    output logic [NUM_SLAVES-1:0]          HSEL_S,
    output logic                           HREADY,
    output logic                           HRESP,
    output logic [DATA_W-1:0]              HRDATA,
    output logic [7:0]                     DEC_ERR_CNT,
    output logic [31:0]                    DEC_ERR_ADDR
);

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

    ds_state_t               ds_state;
    ds_state_t               ds_next;
    // Slave select bits plus the default-slave bit at index NUM_SLAVES.
    logic [NUM_SLAVES:0]     sel_q;
    logic                    unmapped;
    logic                    err_entry;

    // Only HTRANS[1] distinguishes active transfers from IDLE/BUSY.
    logic                    unused_htrans_lsb;
    assign unused_htrans_lsb = HTRANS[0];

    // Address-phase decode; the lowest matching index wins so HSEL_S is one-hot or zero.
    always_comb begin
        logic found;
        HSEL_S = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!found && (((HADDR[31:16] ^ SLV_BASE[16*i +: 16]) & SLV_MASK[16*i +: 16]) == 16'h0)) begin
                HSEL_S[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign unmapped  = HTRANS[1] && (HSEL_S == '0);
    // HREADY is forced low in DS_ERR1, so this only fires from DS_IDLE or DS_ERR2.
    assign err_entry = HREADY && unmapped;

    // Data-phase response mux; the default-slave bit overrides with the two-cycle ERROR pattern.
    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) begin
                HREADY = HREADY_S[i];
                HRESP  = HRESP_S[i];
                HRDATA = HRDATA_S[DATA_W*i +: DATA_W];
            end
        end
        if (sel_q[NUM_SLAVES]) begin
            HREADY = (ds_state == DS_ERR2);
            HRESP  = 1'b1;
            HRDATA = '0;
        end
    end

    // Data-phase select advances only when the current data phase completes.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            sel_q <= '0;
        end else if (HREADY) begin
            sel_q <= {unmapped, HSEL_S};
        end
    end

    // Default-slave state register.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            ds_state <= DS_IDLE;
        end else begin
            ds_state <= ds_next;
        end
    end

    // Default-slave next state: ERR1 always completes into ERR2; ERR2 may chain straight into another error.
    always_comb begin
        ds_next = ds_state;
        case (ds_state)
            DS_IDLE: if (err_entry) ds_next = DS_ERR1;
            DS_ERR1: ds_next = DS_ERR2;
            DS_ERR2: ds_next = unmapped ? DS_ERR1 : DS_IDLE;
            default: ds_next = DS_IDLE;
        endcase
    end

    // Error statistics: a new error wins over a coincident clear, leaving count=1.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            DEC_ERR_CNT  <= 8'd0;
            DEC_ERR_ADDR <= 32'd0;
        end else if (err_entry) begin
            DEC_ERR_ADDR <= HADDR;
            if (ERR_CLR) begin
                DEC_ERR_CNT <= 8'd1;
            end else if (DEC_ERR_CNT != 8'hFF) begin
                DEC_ERR_CNT <= DEC_ERR_CNT + 8'd1;
            end
        end else if (ERR_CLR) begin
            DEC_ERR_CNT  <= 8'd0;
            DEC_ERR_ADDR <= 32'd0;
        end
    end

endmodule
